// File: rtl/controller_poller.sv
// Polls both serial controller ports on each start pulse; start-to-valid is 17*PulseCycles+1 cycles.
// A start seen while busy is dropped; button outputs change only in the single DONE cycle.
module controller_poller #(
  parameter int PulseCycles = 6
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       start,
  output logic       controller_latch,
  output logic       controller_clk,
  input  logic       controller_1_data_in_B,
  input  logic       controller_2_data_in_B,
  output logic [7:0] controller_1_buttons_out,
  output logic [7:0] controller_2_buttons_out,
  output logic       busy,
  output logic       valid
);

  if (PulseCycles < 2) begin : g_param_check
    $error("controller_poller: PulseCycles must be at least 2");
  end

  localparam int PhW = $clog2(PulseCycles);
  localparam logic [PhW-1:0] PhLast = PhW'(PulseCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LOW,
    S_CLK_HIGH,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [PhW-1:0] phase;
  logic [2:0]     bit_idx;
  logic           phase_last;
  logic [1:0]     sync_1;
  logic [1:0]     sync_2;
  logic [7:0]     shift_1;
  logic [7:0]     shift_2;
  logic           latch_nxt;
  logic           clk_nxt;
  logic           busy_nxt;
  logic           valid_nxt;

  assign phase_last = (phase == PhLast);

  // Controller data is asynchronous to clk_1.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {sync_1[0], controller_1_data_in_B};
      sync_2 <= {sync_2[0], controller_2_data_in_B};
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_LATCH;
      S_LATCH:    if (phase_last) state_nxt = S_CLK_LOW;
      S_CLK_LOW:  if (phase_last) state_nxt = S_CLK_HIGH;
      S_CLK_HIGH: if (phase_last) state_nxt = (bit_idx == 3'd7) ? S_DONE : S_CLK_LOW;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      bit_idx <= '0;
      shift_1 <= '0;
      shift_2 <= '0;
    end else begin
      if (state == S_IDLE || state_nxt != state) begin
        phase <= '0;
      end else begin
        phase <= phase + PhW'(1);
      end

      if (state == S_IDLE) begin
        bit_idx <= '0;
      end else if (state == S_CLK_HIGH && phase_last && bit_idx != 3'd7) begin
        bit_idx <= bit_idx + 3'd1;
      end

      // Sample at the end of the low phase, just before the rising edge advances the pads.
      if (state == S_CLK_LOW && phase_last) begin
        shift_1 <= {shift_1[6:0], ~sync_1[1]};
        shift_2 <= {shift_2[6:0], ~sync_2[1]};
      end
    end
  end

  // Outputs decode the next state so the registered pins line up with the state they describe.
  always_comb begin
    latch_nxt = (state_nxt == S_LATCH);
    clk_nxt   = (state_nxt != S_CLK_LOW);
    busy_nxt  = (state_nxt != S_IDLE);
    valid_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      controller_latch         <= 1'b0;
      controller_clk           <= 1'b1;
      busy                     <= 1'b0;
      valid                    <= 1'b0;
      controller_1_buttons_out <= 8'h00;
      controller_2_buttons_out <= 8'h00;
    end else begin
      controller_latch <= latch_nxt;
      controller_clk   <= clk_nxt;
      busy             <= busy_nxt;
      valid            <= valid_nxt;
      if (valid_nxt) begin
        controller_1_buttons_out <= shift_1;
        controller_2_buttons_out <= shift_2;
      end
    end
  end

endmodule

// File: doc/controller_poller.md
# controller_poller

Sequencer for the two serial game-controller ports. On each `start` pulse (normally the vblank strobe) it drives the shared latch/clock lines through one full 8-bit read and shifts both controllers' active-low data in parallel. It then publishes both button bytes as active-high registers for the CPU-facing `controller_*_buttons_out` path. It sits inside `top` between the controller pins and the memory-mapped controller registers, and runs on the CPU clock.

## Interface

- `PulseCycles`, default 6: length in `clk_1` cycles of the latch pulse and of each clock half-phase. Minimum 2; smaller values must cause an elaboration error.

- `clk_1`  in  1  CPU clock, all logic on rising edge
- `rst`  in  1  reset (asynchronous, active-high)
- `start`  in  1  request a poll; sampled only in IDLE
- `controller_latch`  out  1  latch to both controllers, active-high
- `controller_clk`  out  1  shift clock to both controllers, idles high
- `controller_1_data_in_B`  in  1  serial data from controller 1, active-low, asynchronous
- `controller_2_data_in_B`  in  1  serial data from controller 2, active-low, asynchronous
- `controller_1_buttons_out`  out  8  last completed read of controller 1, 1 = pressed
- `controller_2_buttons_out`  out  8  last completed read of controller 2, 1 = pressed
- `busy`  out  1  high whenever state ≠ IDLE
- `valid`  out  1  one-cycle pulse when the button outputs update

## Operation

- **Input synchronisation:** each data input passes through a 2-flop synchroniser before use.
- **States:** IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE. A phase counter of width `$clog2(PulseCycles)` and a 3-bit bit index drive the transitions.
- **IDLE:** when `start`=1, go to LATCH and clear the phase counter and bit index.
- **LATCH:** `controller_latch`=1 for `PulseCycles` cycles, then go to CLK_LOW.
- **CLK_LOW:** `controller_clk`=0 for `PulseCycles` cycles.
  - On the last cycle, shift the inverted synchronised data into both shift registers, MSB first. The first bit read (button A) ends in bit 7; the eighth ends in bit 0.
  - Then go to CLK_HIGH.
- **CLK_HIGH:** `controller_clk`=1 for `PulseCycles` cycles. The rising edge advances the controllers.
  - If bit index = 7, go to DONE; otherwise increment the bit index and go to CLK_LOW.
  - Eight clock pulses are issued in total.
- **DONE (one cycle):** copy the shift registers to `controller_*_buttons_out`, assert `valid`, return to IDLE.
- **start while busy:** ignored; no queueing. `start` held high in IDLE restarts the poll immediately after DONE.
- **Output stability:** button outputs change only in DONE and never show partial reads.
- **Reset values:** `controller_latch`=0, `controller_clk`=1, both button outputs 8'h00, `busy`=0, `valid`=0, state IDLE, synchronisers cleared.
- **Reset mid-poll:** aborts immediately to the reset values; the partial read is discarded.

## Timing

- Numbering: cycle 0 is the edge at which `start`=1 is registered in IDLE. P = `PulseCycles`.
- All outputs are registered (no combinational paths from inputs).
- `busy`: high in cycles 1 .. 17P+1.
- `controller_latch`: high in cycles 1 .. P.
- Controller clock pulse k (k = 0..7):
  - low in cycles P+1+2Pk .. 2P+2Pk
  - high in cycles 2P+1+2Pk .. 3P+2Pk
- Bit k is sampled at the end of cycle 2P+2Pk from the synchroniser output. This is at least P cycles after the preceding latch fall or rising clock edge, so 2-cycle synchroniser latency is covered for P ≥ 2.
- DONE is cycle 17P+1: outputs update and `valid`=1.
- IDLE at cycle 17P+2; the earliest next accepted `start` is at that edge.
- Poll period with `start` tied high: 17P+2 cycles.

## Test plan

- **Basic read:** P=6, controller models (codebase `controller` module, active-low serial) driven with buttons 8'hA5 and 8'h3C; pulse `start` → latch high cycles 1–6, 8 clock pulses, `valid` at cycle 103, outputs 8'hA5 / 8'h3C, `busy` low at cycle 104.
- **Reset values and mid-poll abort:**
  - Assert `rst` at time 0: latch=0, clk=1, outputs 8'h00, `busy`=0.
  - Start a poll, assert `rst` at cycle 40: all outputs return to reset values immediately, no `valid` pulse.
- **Ignored start:** pulse `start` again at cycle 20 of a poll → exactly one `valid` pulse, at cycle 103, and no latch pulse until after IDLE.
- **Back-to-back:** `start` tied high with P=2:
  - `valid` every 36 cycles.
  - Change buttons 8'h01 → 8'h80 between polls; next read reports 8'h80.
  - Outputs never show an intermediate value.
- **Minimum P and edge patterns:** P=2, buttons 8'hFF and 8'h00 → outputs 8'hFF / 8'h00; check each clock half-phase is exactly 2 cycles.
- **Idle line levels:** no `start` for 1000 cycles → latch stays 0, clk stays 1, `valid` never asserts.
